// File: rtl/branch_redirect_unit.sv
// Branch redirect unit: resolves control transfers in EX for a predict-not-taken
// front end. It issues a registered redirect, holds flush for a fixed number of
// cycles to kill wrong-path work, and counts resolved and taken transfers.
module branch_redirect_unit #(
    parameter int XLEN          = 32,
    parameter int SQUASH_CYCLES = 2,
    parameter int CNT_W         = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            ex_stall,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic            is_branch,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic            condition_result,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic            misalign_exc,
    output logic [XLEN-1:0] misalign_addr,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    // Handshake: a resolve happens on a clock edge where ex_valid is high,
    // ex_stall is low and the FSM is IDLE. There is no backpressure from fetch;
    // redirect_valid and misalign_exc are single-cycle pulses, and their data
    // outputs hold the last value while the pulse is low.

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_SQUASH = 1'b1;
    localparam logic [3:0] SQ_INIT   = 4'(SQUASH_CYCLES - 1);

    // FSM state is a plain named signal so checkers can bind to it directly.
    logic [0:0]      state;
    logic [3:0]      squash_cnt;
    logic            resolve;
    logic            taken;
    logic            misaligned;
    logic            do_redirect;
    logic [XLEN-1:0] pc_target;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;

    assign resolve = ex_valid & ~ex_stall & (state == ST_IDLE);

    // Target selection: JALR takes priority and clears bit 0, as the ISA requires.
    always_comb begin
        pc_target = ex_pc + ex_imm;
        jalr_sum  = ex_rs1 + ex_imm;
        if (is_jalr) begin
            target = jalr_sum & ~{{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            target = pc_target;
        end
    end

    assign taken       = (is_branch & condition_result) | is_jal | is_jalr;
    assign misaligned  = taken & (target[1:0] != 2'b00);
    assign do_redirect = resolve & taken & ~misaligned;

    // flush tracks the SQUASH state directly, so an async reset drops it at once.
    assign flush = (state == ST_SQUASH);

    // Squash FSM: count down SQUASH_CYCLES cycles after each redirect, ignoring
    // EX traffic (wrong path) and ex_stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            squash_cnt <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (do_redirect) begin
                        state      <= ST_SQUASH;
                        squash_cnt <= SQ_INIT;
                    end
                end
                ST_SQUASH: begin
                    if (squash_cnt == 4'd0) begin
                        state <= ST_IDLE;
                    end else begin
                        squash_cnt <= squash_cnt - 4'd1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    squash_cnt <= 4'd0;
                end
            endcase
        end
    end

    // Registered redirect and misalign pulses; the addresses only load when they fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            misalign_exc   <= 1'b0;
            misalign_addr  <= '0;
        end else begin
            redirect_valid <= do_redirect;
            misalign_exc   <= resolve & misaligned;
            if (do_redirect) begin
                redirect_pc <= target;
            end
            if (resolve & misaligned) begin
                misalign_addr <= target;
            end
        end
    end

    // Performance counters: wrap naturally, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count <= '0;
            taken_count  <= '0;
        end else if (resolve) begin
            if (is_branch) begin
                branch_count <= branch_count + 1'b1;
            end
            if (taken) begin
                taken_count <= taken_count + 1'b1;
            end
        end
    end

endmodule
